// File: rtl/riscuinho_lsu.sv
// Load/store unit sitting behind the integer ALU. Runs one data-memory access
// at a time over a request/ready bus, returning extended load data or issuing
// lane-aligned store strobes. Misaligned accesses never reach the bus; a
// stalled bus is abandoned after TIMEOUT cycles and reported through err.
//
// Bus handshake: mem_req is held high for the whole access, together with
// stable mem_addr/mem_we/mem_wstrb/mem_wdata. The access completes on the
// first rising edge where mem_req and mem_ready are both high; mem_ready at
// any other time is ignored.
module riscuinho_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           alu_op,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [15:0] OP_LB  = 16'h0003;
    localparam logic [15:0] OP_LH  = 16'h0083;
    localparam logic [15:0] OP_LW  = 16'h0103;
    localparam logic [15:0] OP_LBU = 16'h0203;
    localparam logic [15:0] OP_LHU = 16'h0283;
    localparam logic [15:0] OP_SB  = 16'h0023;
    localparam logic [15:0] OP_SH  = 16'h00A3;
    localparam logic [15:0] OP_SW  = 16'h0123;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             op_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   sd_q;
    logic [31:0]             cnt_q;

    logic                    op_ok, is_half_in, is_word_in, mis_in;
    logic                    accept, timeout_hit;
    logic                    is_store_q;
    logic [1:0]              off_q;
    logic [3:0]              wstrb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   ext_data;

    // Decode the incoming op: legality and access size for the alignment check.
    always_comb begin
        op_ok      = 1'b0;
        is_half_in = 1'b0;
        is_word_in = 1'b0;
        case (alu_op)
            OP_LB, OP_LBU, OP_SB: op_ok = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                op_ok      = 1'b1;
                is_half_in = 1'b1;
            end
            OP_LW, OP_SW: begin
                op_ok      = 1'b1;
                is_word_in = 1'b1;
            end
            default: ;
        endcase
    end

    assign mis_in = (is_half_in && addr[0]) || (is_word_in && (addr[1:0] != 2'b00));

    // Next-state logic; the timeout fires on the last allowed ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op_ok) begin
                    accept  = 1'b1;
                    state_d = mis_in ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign off_q      = addr_q[1:0];
    assign is_store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

    // Store lane strobes and replicated write data from the latched request.
    always_comb begin
        wstrb_q = 4'b0000;
        wdata_q = '0;
        case (op_q)
            OP_SB: begin
                wstrb_q = 4'b0001 << off_q;
                wdata_q = {4{sd_q[7:0]}};
            end
            OP_SH: begin
                wstrb_q = 4'b0011 << off_q;
                wdata_q = {2{sd_q[15:0]}};
            end
            OP_SW: begin
                wstrb_q = 4'b1111;
                wdata_q = sd_q;
            end
            default: ;
        endcase
    end

    // Load extraction: move the addressed lane to bit 0, then extend.
    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        ext_data = '0;
        case (op_q)
            OP_LB:   ext_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  ext_data = {24'h000000, shifted[7:0]};
            OP_LH:   ext_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  ext_data = {16'h0000, shifted[15:0]};
            OP_LW:   ext_data = mem_rdata;
            default: ext_data = '0;
        endcase
    end

    assign busy      = (state_q == ACCESS);
    assign done      = (state_q == RESP);
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && is_store_q;
    assign mem_addr  = (state_q == ACCESS) ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_wstrb = (state_q == ACCESS) ? wstrb_q : 4'b0000;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

    // State, request latch, timeout counter and the held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            sd_q       <= '0;
            cnt_q      <= '0;
            load_data  <= '0;
            misaligned <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= alu_op;
                addr_q <= addr;
                sd_q   <= store_data;
                cnt_q  <= '0;
                if (mis_in) begin
                    load_data  <= '0;
                    misaligned <= 1'b1;
                    err        <= 1'b0;
                end
            end
            if (state_q == ACCESS) begin
                if (mem_ready) begin
                    load_data  <= ext_data;
                    misaligned <= 1'b0;
                    err        <= 1'b0;
                end else if (timeout_hit) begin
                    load_data  <= '0;
                    misaligned <= 1'b0;
                    err        <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end
        end
    end

endmodule
